// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared state encoding and width helper for the FSM_C test sequencer
package fsm_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    INIT  = ST_INIT,
    APPLY = ST_APPLY,
    DONE  = ST_DONE
  } state_t;

  // Width able to hold every value 0..w (bit counts and lengths).
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fsm_seq_shifter.sv
// rtl/fsm_seq_shifter.sv - captured pattern, bit index and Y capture register
module fsm_seq_shifter
  import fsm_seq_pkg::*;
#(
  parameter int WORD_W = 8,
  localparam int CNT_W = cnt_w(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic              y,
  input  logic [WORD_W-1:0] pattern,
  output logic              cur_bit,
  output logic              next_bit,
  output logic [CNT_W-1:0]  idx,
  output logic [WORD_W-1:0] y_word
);

  // One spare top bit keeps next_bit legal even for a one-bit pattern.
  logic [WORD_W:0]   sh;
  logic [WORD_W-1:0] mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh     <= '0;
      mask   <= '0;
      idx    <= '0;
      y_word <= '0;
    end else if (load) begin
      sh     <= {1'b0, pattern};
      mask   <= WORD_W'(1);
      idx    <= '0;
      y_word <= '0;
    end else if (advance) begin
      sh     <= sh >> 1;
      mask   <= mask << 1;
      idx    <= idx + CNT_W'(1);
      if (y) begin
        y_word <= y_word | mask;
      end
    end
  end

  assign cur_bit  = sh[0];
  assign next_bit = sh[1];

endmodule

// File: rtl/fsm_c_sequencer.sv
// rtl/fsm_c_sequencer.sv - drives a bit pattern into FSM_C and collects its Y response
// Optional abort port pair enabled by defining FSMSEQ_ABORT_EN.
module fsm_c_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int Y_LAT  = 1,
  localparam int CNT_W = cnt_w(WORD_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [WORD_W-1:0] pattern,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              fsm_rst,
  output logic              e_out,
  input  logic              y_in,
`ifdef FSMSEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic [WORD_W-1:0] y_word,
  output logic [CNT_W-1:0]  hits
);

  localparam int LAT_W = (Y_LAT < 1) ? 1 : $clog2(Y_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(Y_LAT);
  localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(WORD_W);

  state_t           state;
  logic [LAT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] idx;
  logic             cur_bit;
  logic             next_bit;
  logic             load;
  logic             advance;
  logic             abort_now;
  logic             last_bit;

  assign load     = (state == IDLE) && start;
  assign advance  = (state == APPLY) && (cnt == '0) && !abort_now;
  assign last_bit = (idx + CNT_W'(1)) == len_q;

`ifdef FSMSEQ_ABORT_EN
  assign abort_now = abort && ((state == INIT) || (state == APPLY));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      aborted <= 1'b0;
    end else if (load) begin
      aborted <= 1'b0;
    end else if (abort_now) begin
      aborted <= 1'b1;
    end
  end
`else
  assign abort_now = 1'b0;
`endif

  fsm_seq_shifter #(.WORD_W(WORD_W)) u_shifter (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .advance  (advance),
    .y        (y_in),
    .pattern  (pattern),
    .cur_bit  (cur_bit),
    .next_bit (next_bit),
    .idx      (idx),
    .y_word   (y_word)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      fsm_rst <= 1'b1;
      e_out   <= 1'b0;
      cnt     <= '0;
      hits    <= '0;
      len_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          fsm_rst <= 1'b0;
          e_out   <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            state   <= INIT;
            busy    <= 1'b1;
            fsm_rst <= 1'b1;
            hits    <= '0;
            len_q   <= (len > LEN_MAX) ? LEN_MAX : len;
          end
        end
        INIT: begin
          fsm_rst <= 1'b0;
          if (abort_now || (len_q == '0)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= APPLY;
            e_out <= cur_bit;
            cnt   <= LAT_LOAD;
          end
        end
        APPLY: begin
          // Abort wins over sampling: the bit in flight is never recorded.
          if (abort_now) begin
            state <= DONE;
            done  <= 1'b1;
            e_out <= 1'b0;
          end else if (cnt == '0) begin
            hits <= hits + CNT_W'(y_in);
            if (last_bit) begin
              state <= DONE;
              done  <= 1'b1;
              e_out <= 1'b0;
            end else begin
              e_out <= next_bit;
              cnt   <= LAT_LOAD;
            end
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_c_sequencer.sv
// tb/tb_fsm_c_sequencer.sv - directed self-checking bench for fsm_c_sequencer
module tb_fsm_c_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       busy, done, fsm_rst, e_out, y_in;
  logic [7:0] y_word;
  logic [3:0] hits;
`ifdef FSMSEQ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks = 0;
  int failures = 0;

  int          busy_cyc, done_at, e_ones;
  logic [31:0] e_trace, r_trace;

  always #5 CLK = ~CLK;

  fsm_c_sequencer #(.WORD_W(8), .Y_LAT(1)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .fsm_rst (fsm_rst),
    .e_out   (e_out),
    .y_in    (y_in),
`ifdef FSMSEQ_ABORT_EN
    .abort   (abort),
    .aborted (aborted),
`endif
    .y_word  (y_word),
    .hits    (hits)
  );

  // FSM_C stand-in: Y is E delayed by one clock, cleared by its reset.
  always @(posedge CLK or posedge RST) begin
    if (RST) y_in <= 1'b0;
    else if (fsm_rst) y_in <= 1'b0;
    else y_in <= e_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a run and records per-cycle traces; cycle 1 is the INIT cycle.
  task automatic do_run(input logic [7:0] pat, input logic [3:0] l);
    @(negedge CLK);
    pattern = pat;
    len = l;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    busy_cyc = 0;
    done_at = -1;
    e_ones = 0;
    e_trace = '0;
    r_trace = '0;
    for (int c = 1; c <= 100 && busy; c++) begin
      busy_cyc++;
      if (done) done_at = c;
      if (e_out) e_ones++;
      if (c < 32) begin
        e_trace[c] = e_out;
        r_trace[c] = fsm_rst;
      end
      @(negedge CLK);
    end
    chk("run_ended", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    start = 1'b0;
    pattern = 8'h00;
    len = 4'd0;
`ifdef FSMSEQ_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fsm_rst", {31'd0, fsm_rst}, 32'd1);
    chk("rst_e_out", {31'd0, e_out}, 32'd0);
    chk("rst_y_word", {24'd0, y_word}, 32'd0);
    chk("rst_hits", {28'd0, hits}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_fsm_rst", {31'd0, fsm_rst}, 32'd0);

    // 1: full 8-bit run
    do_run(8'hB6, 4'd8);
    chk("t1_busy_cycles", busy_cyc, 32'd18);
    chk("t1_done_at", done_at, 32'd18);
    chk("t1_e_trace", e_trace, 32'h0003_3CF0);
    chk("t1_rst_trace", r_trace, 32'h0000_0002);
    chk("t1_y_word", {24'd0, y_word}, 32'hB6);
    chk("t1_hits", {28'd0, hits}, 32'd5);

    // 2: zero length
    do_run(8'hFF, 4'd0);
    chk("t2_busy_cycles", busy_cyc, 32'd2);
    chk("t2_done_at", done_at, 32'd2);
    chk("t2_e_ones", e_ones, 32'd0);
    chk("t2_rst_trace", r_trace, 32'h0000_0002);
    chk("t2_y_word", {24'd0, y_word}, 32'd0);
    chk("t2_hits", {28'd0, hits}, 32'd0);

    // 3: length above WORD_W is clamped
    do_run(8'h0F, 4'd12);
    chk("t3_busy_cycles", busy_cyc, 32'd18);
    chk("t3_e_trace", e_trace, 32'h0000_03FC);
    chk("t3_hits", {28'd0, hits}, 32'd4);
    chk("t3_y_word", {24'd0, y_word}, 32'h0F);

    // 4: reset while bit 3 is driven
    @(negedge CLK);
    pattern = 8'hB6;
    len = 4'd8;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (7) @(negedge CLK);
    chk("t4_pre_hits", {28'd0, hits}, 32'd2);
    chk("t4_pre_busy", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    #1;
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_fsm_rst", {31'd0, fsm_rst}, 32'd1);
    chk("t4_e_out", {31'd0, e_out}, 32'd0);
    chk("t4_hits", {28'd0, hits}, 32'd0);
    chk("t4_y_word", {24'd0, y_word}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("t4_no_done_a", {31'd0, done}, 32'd0);
    chk("t4_idle_fsm_rst", {31'd0, fsm_rst}, 32'd0);
    @(negedge CLK);
    chk("t4_no_done_b", {31'd0, done}, 32'd0);
    do_run(8'hB6, 4'd8);
    chk("t4_rerun_busy", busy_cyc, 32'd18);
    chk("t4_rerun_y_word", {24'd0, y_word}, 32'hB6);
    chk("t4_rerun_hits", {28'd0, hits}, 32'd5);

    // 5: start held high, pattern changed mid-run
    @(negedge CLK);
    pattern = 8'h3C;
    len = 4'd8;
    start = 1'b1;
    @(negedge CLK);
    repeat (4) @(negedge CLK);
    pattern = 8'h07;
    repeat (13) @(negedge CLK);
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_busy_in_done", {31'd0, busy}, 32'd1);
    @(negedge CLK);
    chk("t5_idle_gap", {31'd0, busy}, 32'd0);
    chk("t5_run1_y_word", {24'd0, y_word}, 32'h3C);
    chk("t5_run1_hits", {28'd0, hits}, 32'd4);
    @(negedge CLK);
    chk("t5_run2_busy", {31'd0, busy}, 32'd1);
    chk("t5_run2_fsm_rst", {31'd0, fsm_rst}, 32'd1);
    start = 1'b0;
    for (int c = 0; c < 40 && busy; c++) @(negedge CLK);
    chk("t5_run2_end", {31'd0, busy}, 32'd0);
    chk("t5_run2_y_word", {24'd0, y_word}, 32'h07);
    chk("t5_run2_hits", {28'd0, hits}, 32'd3);

`ifdef FSMSEQ_ABORT_EN
    // 6: abort while bit 3 is driven
    @(negedge CLK);
    pattern = 8'hB6;
    len = 4'd8;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (7) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_aborted", {31'd0, aborted}, 32'd1);
    chk("t6_e_out", {31'd0, e_out}, 32'd0);
    chk("t6_y_word", {24'd0, y_word}, 32'h06);
    chk("t6_hits", {28'd0, hits}, 32'd2);
    @(negedge CLK);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    chk("t6_aborted_held", {31'd0, aborted}, 32'd1);
    do_run(8'h01, 4'd1);
    chk("t6_aborted_cleared", {31'd0, aborted}, 32'd0);
    chk("t6_rerun_hits", {28'd0, hits}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
